// File: rtl/mux_parity_engine_pkg.sv
// Shared definitions for mux_parity_engine: FSM state encodings and the XOR truth-table generator.
// Used by both the default build and the MUX_LUT_PROG_EN build.
package mux_parity_engine_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Large enough for K up to 7; callers slice off the low 2^(K+1) entries.
    localparam int LUT_MAX = 256;

    function automatic logic [LUT_MAX-1:0] lut_xor();
        logic [LUT_MAX-1:0] table_bits;
        table_bits = '0;
        for (int i = 0; i < LUT_MAX; i++) begin
            table_bits[i] = ^(i[7:0]);
        end
        return table_bits;
    endfunction

endpackage

// File: rtl/mux_parity_engine_mux_lut.sv
// Parametrised 2^(K+1):1 mux that looks up one truth-table bit.
// The select is the concatenation {chunk, acc}.
module mux_lut #(
    parameter int K = 2
) (
    input  logic [2**(K+1)-1:0] lut_table,
    input  logic [K:0]          sel,
    output logic                out_bit
);

    assign out_bit = lut_table[sel];

endmodule

// File: rtl/mux_parity_engine.sv
// Multi-cycle parity engine folding a WIDTH-bit word K bits per cycle through one mux-LUT.
// Define MUX_LUT_PROG_EN to expose a programmable cfg_lut truth table instead of the fixed XOR table.
module mux_parity_engine
    import mux_parity_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_result
`ifdef MUX_LUT_PROG_EN
    ,
    input  logic [2**(K+1)-1:0] cfg_lut
`endif
);

    localparam int BEATS = WIDTH / K;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LUT_N = 2**(K+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic [LUT_N-1:0] lut_table;
    logic             next_acc;
    logic             accept;

`ifdef MUX_LUT_PROG_EN
    assign lut_table = cfg_lut;
`else
    localparam logic [LUT_MAX-1:0] LUT_XOR_FULL = lut_xor();
    assign lut_table = LUT_XOR_FULL[LUT_N-1:0];
`endif

    mux_lut #(.K(K)) u_mux_lut (
        .lut_table (lut_table),
        .sel       ({shreg[K-1:0], acc}),
        .out_bit   (next_acc)
    );

    // Held low during reset so no upstream word is lost while the engine is cleared.
    assign in_ready = rst_n & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // An accept in DONE retires the held result and starts the next word on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            acc        <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= 1'b0;
        end else if (accept) begin
            shreg     <= in_data;
            acc       <= 1'b0;
            cnt       <= '0;
            state     <= ST_BUSY;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    acc   <= next_acc;
                    shreg <= shreg >> K;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        out_result <= next_acc;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
